lfsr_gen: RTL and testbench
===========================

Name: lfsr_gen

Overview:
- Fibonacci-style linear feedback shift register producing a pseudo-random sequence, one new state per enabled clock.
- Default configuration is a 4-bit maximal-length sequence (period 15) with reset seed 4'b1110.
- Used as a lightweight pattern and test-stimulus source.
- Supports runtime seed load and all-zero lockup recovery.

Parameters:
- WIDTH, 4, state/output width; legal range 3..32.
- TAPS, 4'b1100, feedback tap mask; bit i set means state[i] is XORed into the feedback. Width WIDTH.
- SEED, 4'b1110, reset and lockup-recovery state; must be nonzero. Width WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  advance enable; state shifts only when high.
- load  input  1  synchronous seed load strobe.
- seed_i  input  WIDTH  value captured when load=1.
- lfsr_o  output  WIDTH  current LFSR state, driven directly from the state register.
- lockup_o  output  1  one-cycle pulse when the all-zero state is detected and recovered.

Behaviour:
- Reset:
  - reset low asynchronously forces state=SEED and lockup_o=0.
  - Release is sampled on clk.
  - The first rising edge with reset high applies normal next-state rules.
- Feedback:
  - fb = XOR reduction of (state & TAPS).
  - Shift left: next = {state[WIDTH-2:0], fb}.
- Priority per rising edge, highest first:
  1. load=1: state <= seed_i. Load overrides en.
  2. state==0 and en=1: state <= SEED, lockup_o <= 1 for one cycle.
  3. en=1: state <= shifted value.
  4. Otherwise: hold.
- lockup_o is 0 in every other cycle. It is registered, so it is high in the cycle after the recovery edge.
- Loading seed_i=0 is allowed. The state stays 0 while en=0. The first enabled edge recovers to SEED.
- lfsr_o changes only on clk edges or on asynchronous reset, with no combinational path from inputs.
- With default parameters, the sequence from SEED, one step per enabled edge, is: 1110, 1100, 1000, 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, then 1110 again (period 15, wraps).
- A reset asserted mid-sequence immediately returns lfsr_o to SEED and clears lockup_o.

Optional Feature:
- Macro: LFSR_PERIOD_FLAG_EN.
- When defined:
  - Adds output wrap_o (1 bit).
  - Adds a step counter sized ceil(log2(2^WIDTH)) bits.
  - The counter increments on each enabled shift.
  - wrap_o pulses high for one cycle when the state returns to the value most recently loaded, reset to, or recovered to (the reference state).
  - On that wrap the counter clears.
  - The reference state is updated on load, reset and lockup recovery; the counter clears on each.
- When undefined:
  - No wrap_o port and no counter logic.
  - All other behaviour is identical.

Test Plan:
- Reset low 2 cycles, then release with en=1 → lfsr_o=1110 during reset. Then 1100, 1000, 0001, 0010 on successive edges.
- Run with en=1 for 32 cycles after reset → the exact 15-state default sequence, repeating with period 15 and no 0000 state.
- Hold en=0 for 5 cycles mid-sequence (state 1001) → lfsr_o stays 1001. After en=1, the next value is 0011.
- load=1, seed_i=0101, en=1 → lfsr_o=0101 next cycle, then 1011, 0111.
- load seed_i=0000, hold en=0 for 3 cycles → lfsr_o=0000. Then en=1 → lfsr_o=1110 and lockup_o=1 for exactly one cycle.
- Assert reset low asynchronously between edges while lfsr_o=0110 → lfsr_o=1110 immediately. With LFSR_PERIOD_FLAG_EN defined, wrap_o pulses exactly every 15 enabled cycles.

Source files
------------

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci LFSR with seed load and all-zero lockup recovery (optional LFSR_PERIOD_FLAG_EN adds wrap_o)
module lfsr_gen #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
    parameter logic [WIDTH-1:0] SEED  = 4'b1110
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] lfsr_o,
    output logic             lockup_o
`ifdef LFSR_PERIOD_FLAG_EN
    ,
    output logic             wrap_o
`endif
);

    logic [WIDTH-1:0] state;
    logic             fb;
    logic [WIDTH-1:0] shifted;
    logic             is_zero;

    assign fb      = ^(state & TAPS);
    assign shifted = {state[WIDTH-2:0], fb};
    assign is_zero = (state == '0);
    assign lfsr_o  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= SEED;
            lockup_o <= 1'b0;
        end else begin
            lockup_o <= 1'b0;
            if (load) begin
                state <= seed_i;
            end else if (en && is_zero) begin
                // All-zero is a fixed point of the XOR feedback; reseed to escape it
                state    <= SEED;
                lockup_o <= 1'b1;
            end else if (en) begin
                state <= shifted;
            end
        end
    end

`ifdef LFSR_PERIOD_FLAG_EN
    logic [WIDTH-1:0] ref_state;
    logic [WIDTH-1:0] step_cnt;

    // ref_state tracks the last seeded value so wrap_o marks one full period from it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_state <= SEED;
            step_cnt  <= '0;
            wrap_o    <= 1'b0;
        end else begin
            wrap_o <= 1'b0;
            if (load) begin
                ref_state <= seed_i;
                step_cnt  <= '0;
            end else if (en && is_zero) begin
                ref_state <= SEED;
                step_cnt  <= '0;
            end else if (en) begin
                if (shifted == ref_state) begin
                    wrap_o   <= 1'b1;
                    step_cnt <= '0;
                end else begin
                    step_cnt <= step_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed self-checking bench for lfsr_gen
module tb_lfsr_gen;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [3:0] seed_i;
    logic [3:0] lfsr_o;
    logic       lockup_o;
`ifdef LFSR_PERIOD_FLAG_EN
    logic       wrap_o;
`endif

    int checks;
    int errors;

    logic [3:0] seq [15] = '{4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010,
                             4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101,
                             4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111};

    lfsr_gen dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .seed_i   (seed_i),
        .lfsr_o   (lfsr_o),
        .lockup_o (lockup_o)
`ifdef LFSR_PERIOD_FLAG_EN
        ,
        .wrap_o   (wrap_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        seed_i = 4'b0000;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        en     = 1'b1;
        load   = 1'b0;
        seed_i = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (lfsr_o !== 4'b1110 || lockup_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: lfsr_o=%b lockup_o=%b expected 1110/0", i, lfsr_o, lockup_o);
            end
        end
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (lfsr_o !== seq[i]) begin
                errors++;
                $display("FAIL reset_release step %0d: lfsr_o=%b expected %b", i, lfsr_o, seq[i]);
            end
        end
    endtask

    task automatic test_sequence();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            step();
            checks++;
            if (lfsr_o !== seq[i % 15] || lfsr_o === 4'b0000) begin
                errors++;
                $display("FAIL sequence step %0d: lfsr_o=%b expected %b", i, lfsr_o, seq[i % 15]);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (lfsr_o !== 4'b1001) begin
                errors++;
                $display("FAIL hold cycle %0d: lfsr_o=%b expected 1001", i, lfsr_o);
            end
        end
        en = 1'b1;
        step();
        checks++;
        if (lfsr_o !== 4'b0011) begin
            errors++;
            $display("FAIL hold_resume: lfsr_o=%b expected 0011", lfsr_o);
        end
    endtask

    task automatic test_load();
        en     = 1'b1;
        load   = 1'b1;
        seed_i = 4'b0101;
        step();
        checks++;
        if (lfsr_o !== 4'b0101) begin
            errors++;
            $display("FAIL load_capture: lfsr_o=%b expected 0101", lfsr_o);
        end
        load = 1'b0;
        step();
        checks++;
        if (lfsr_o !== 4'b1011) begin
            errors++;
            $display("FAIL load_step1: lfsr_o=%b expected 1011", lfsr_o);
        end
        step();
        checks++;
        if (lfsr_o !== 4'b0111) begin
            errors++;
            $display("FAIL load_step2: lfsr_o=%b expected 0111", lfsr_o);
        end
    endtask

    task automatic test_lockup();
        en     = 1'b0;
        load   = 1'b1;
        seed_i = 4'b0000;
        step();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lfsr_o !== 4'b0000 || lockup_o !== 1'b0) begin
                errors++;
                $display("FAIL lockup_zero_hold cycle %0d: lfsr_o=%b lockup_o=%b expected 0000/0", i, lfsr_o, lockup_o);
            end
            step();
        end
        en = 1'b1;
        step();
        checks++;
        if (lfsr_o !== 4'b1110 || lockup_o !== 1'b1) begin
            errors++;
            $display("FAIL lockup_recover: lfsr_o=%b lockup_o=%b expected 1110/1", lfsr_o, lockup_o);
        end
        step();
        checks++;
        if (lfsr_o !== 4'b1100 || lockup_o !== 1'b0) begin
            errors++;
            $display("FAIL lockup_pulse_end: lfsr_o=%b lockup_o=%b expected 1100/0", lfsr_o, lockup_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (lfsr_o !== 4'b0110) begin
            errors++;
            $display("FAIL async_pre: lfsr_o=%b expected 0110", lfsr_o);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (lfsr_o !== 4'b1110) begin
            errors++;
            $display("FAIL async_reset: lfsr_o=%b expected 1110", lfsr_o);
        end
        reset = 1'b1;
        // async reset must also clear a pending lockup pulse
        en     = 1'b0;
        load   = 1'b1;
        seed_i = 4'b0000;
        @(posedge clk);
        #1;
        load = 1'b0;
        en   = 1'b1;
        step();
        checks++;
        if (lockup_o !== 1'b1) begin
            errors++;
            $display("FAIL async_lockup_setup: lockup_o=%b expected 1", lockup_o);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (lockup_o !== 1'b0 || lfsr_o !== 4'b1110) begin
            errors++;
            $display("FAIL async_lockup_clear: lfsr_o=%b lockup_o=%b expected 1110/0", lfsr_o, lockup_o);
        end
        reset = 1'b1;
    endtask

`ifdef LFSR_PERIOD_FLAG_EN
    task automatic test_wrap();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            step();
            checks++;
            if (wrap_o !== ((i % 15) == 0)) begin
                errors++;
                $display("FAIL wrap step %0d: wrap_o=%b expected %b", i, wrap_o, ((i % 15) == 0));
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequence();
        test_hold();
        test_load();
        test_lockup();
        test_async_reset();
`ifdef LFSR_PERIOD_FLAG_EN
        test_wrap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
